// File: rtl/tl_inflight_tracker_pkg.sv
// Shared constants, types and helpers for the TileLink in-flight tracker.
package tl_tracker_pkg;

  localparam int NUM_SOURCES = 8;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  // D-channel opcodes
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  // Sticky error flags, kept together so they can be OR-ed and cleared as a unit.
  typedef struct packed {
    logic dup;
    logic no_req;
    logic mismatch;
    logic timeout;
  } err_flags_t;

  // Beats in a message of 2^size bytes on a link of 2^beat_log2 bytes per beat.
  // Clamped at 8 beats so a 3-bit beat counter always covers the message.
  function automatic logic [3:0] beats_from_size(input logic [2:0] size, input int beat_log2);
    int sz;
    int sh;
    sz = int'(size);
    if (sz <= beat_log2) return 4'd1;
    sh = sz - beat_log2;
    if (sh >= 3) return 4'd8;
    return 4'd1 << sh;
  endfunction

endpackage

// File: rtl/tl_inflight_tracker_if.sv
// A/D channel signals observed by the tracker. The master side drives the
// bus; the tracker only ever connects through the slave (all-input) modport.
interface tl_inflight_tracker_if;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_size;
  logic [2:0]  a_source;
  logic [31:0] a_address;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_size;
  logic [2:0]  d_source;

  modport master (
    output a_valid, a_ready, a_opcode, a_size, a_source, a_address,
    output d_valid, d_ready, d_opcode, d_size, d_source
  );

  modport slave (
    input a_valid, a_ready, a_opcode, a_size, a_source, a_address,
    input d_valid, d_ready, d_opcode, d_size, d_source
  );
endinterface

// File: rtl/tl_beat_counter.sv
// Per-channel beat counter: flags the first and last beat of the message
// currently on the channel. Only data-bearing multi-beat messages advance it.
module tl_beat_counter
  import tl_tracker_pkg::*;
#(
  parameter int BEAT_BYTES_LOG2 = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fire,
  input  logic [2:0] size,
  input  logic       has_data,
  output logic       first,
  output logic       last
);

  logic [2:0] cnt;
  logic [3:0] beats;
  logic [2:0] last_idx;
  logic       multi;

  assign beats    = beats_from_size(size, BEAT_BYTES_LOG2);
  assign last_idx = 3'(beats - 4'd1);
  assign multi    = has_data && (beats != 4'd1);
  assign first    = (cnt == 3'd0);
  assign last     = !multi || (cnt == last_idx);

  // Advance on each multi-beat data fire, wrapping to 0 after the last beat.
  always_ff @(posedge clock) begin
    if (reset) cnt <= 3'd0;
    else if (fire && multi) cnt <= last ? 3'd0 : cnt + 3'd1;
  end

endmodule

// File: rtl/tl_inflight_tracker.sv
// TileLink in-flight request tracker. Passively watches A/D fires, keeps a
// pending bit per source and raises sticky protocol error flags.
// Optional feature: define TL_INFLIGHT_TIMEOUT_EN to build the idle timeout.
module tl_inflight_tracker
  import tl_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int BEAT_BYTES_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  tl_inflight_tracker_if.slave  bus,
  input  logic                  err_clear,
  output logic [3:0]            inflight_count,
  output logic                  busy,
  output logic                  err_dup_source,
  output logic                  err_no_request,
  output logic                  err_mismatch,
  output logic                  err_timeout,
  output logic [2:0]            err_source
);

  logic a_fire, d_fire;
  logic a_has_data, d_has_data;
  logic a_first, a_last, d_first, d_last;
  logic a_first_evt, d_first_evt, d_last_evt;

  logic [NUM_SOURCES-1:0]      pending, pending_nxt;
  logic [NUM_SOURCES-1:0]      exp_op;
  logic [NUM_SOURCES-1:0][2:0] exp_size;
  logic [3:0]                  count_nxt;
  logic [2:0]                  exp_d_opcode;
  logic [2:0]                  low_src;
  logic [2:0]                  err_src_nxt;
  logic                        timeout_hit;
  err_flags_t                  flags, new_err;

  // Address plays no part in source tracking.
  logic unused_addr;
  assign unused_addr = ^bus.a_address;

  assign a_fire     = bus.a_valid & bus.a_ready;
  assign d_fire     = bus.d_valid & bus.d_ready;
  assign a_has_data = (bus.a_opcode == PUT_FULL) || (bus.a_opcode == PUT_PARTIAL);
  assign d_has_data = (bus.d_opcode == ACK_DATA);

  tl_beat_counter #(.BEAT_BYTES_LOG2(BEAT_BYTES_LOG2)) u_a_beats (
    .clock    (clock),
    .reset    (reset),
    .fire     (a_fire),
    .size     (bus.a_size),
    .has_data (a_has_data),
    .first    (a_first),
    .last     (a_last)
  );

  tl_beat_counter #(.BEAT_BYTES_LOG2(BEAT_BYTES_LOG2)) u_d_beats (
    .clock    (clock),
    .reset    (reset),
    .fire     (d_fire),
    .size     (bus.d_size),
    .has_data (d_has_data),
    .first    (d_first),
    .last     (d_last)
  );

  // The A last-beat flag is not needed: a request is pending from its first beat.
  logic unused_a_last;
  assign unused_a_last = a_last;

  assign a_first_evt  = a_fire & a_first;
  assign d_first_evt  = d_fire & d_first;
  assign d_last_evt   = d_fire & d_last;
  assign exp_d_opcode = exp_op[bus.d_source] ? ACK_DATA : ACK;

`ifdef TL_INFLIGHT_TIMEOUT_EN
  logic [15:0] to_cnt, to_nxt;

  // Idle-with-work counter: runs while busy without D progress, saturates at the limit.
  always_comb begin
    to_nxt = '0;
    if (busy && !d_fire)
      to_nxt = (to_cnt == 16'(TIMEOUT_CYCLES)) ? to_cnt : to_cnt + 16'd1;
  end

  assign timeout_hit = (to_nxt == 16'(TIMEOUT_CYCLES));

  // Timeout counter register.
  always_ff @(posedge clock) begin
    if (reset) to_cnt <= '0;
    else       to_cnt <= to_nxt;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
  assign timeout_hit = 1'b0;
`endif

  // Next pending state, new error events and the source to capture for them.
  always_comb begin
    pending_nxt = pending;
    // Clear before set so a same-cycle reuse of a source keeps the new request.
    if (d_last_evt) pending_nxt[bus.d_source] = 1'b0;
    if (a_first_evt) pending_nxt[bus.a_source] = 1'b1;

    count_nxt = '0;
    for (int i = 0; i < NUM_SOURCES; i++) count_nxt += {3'd0, pending_nxt[i]};

    new_err          = '0;
    new_err.dup      = a_first_evt && pending[bus.a_source] &&
                       !(d_last_evt && (bus.d_source == bus.a_source));
    new_err.no_req   = d_first_evt && !pending[bus.d_source];
    new_err.mismatch = d_first_evt && pending[bus.d_source] &&
                       ((bus.d_opcode != exp_d_opcode) ||
                        (bus.d_size != exp_size[bus.d_source]));
    new_err.timeout  = timeout_hit;

    // A timeout is blamed on the lowest-numbered outstanding source.
    low_src = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--)
      if (pending[i]) low_src = 3'(i);

    // D-side errors win over A-side, which win over the timeout.
    if (new_err.no_req || new_err.mismatch) err_src_nxt = bus.d_source;
    else if (new_err.dup)                    err_src_nxt = bus.a_source;
    else                                     err_src_nxt = low_src;
  end

  // Pending bits, expected-response bookkeeping and the registered count.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending        <= '0;
      exp_op         <= '0;
      exp_size       <= '0;
      inflight_count <= '0;
    end else begin
      pending        <= pending_nxt;
      inflight_count <= count_nxt;
      if (a_first_evt) begin
        exp_op[bus.a_source]   <= (bus.a_opcode == GET);
        exp_size[bus.a_source] <= bus.a_size;
      end
    end
  end

  // Sticky error flags; err_source holds the first error since the last clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      flags      <= '0;
      err_source <= '0;
    end else if (err_clear) begin
      // A new error in the clear cycle survives the clear.
      flags      <= new_err;
      err_source <= (|new_err) ? err_src_nxt : 3'd0;
    end else begin
      flags <= flags | new_err;
      if (!(|flags) && (|new_err)) err_source <= err_src_nxt;
    end
  end

  assign busy           = (inflight_count != 4'd0);
  assign err_dup_source = flags.dup;
  assign err_no_request = flags.no_req;
  assign err_mismatch   = flags.mismatch;
  assign err_timeout    = flags.timeout;

endmodule

// File: tb/tb_tl_inflight_tracker.sv
// Directed bench for tl_inflight_tracker with hand-computed expectations.
module tb_tl_inflight_tracker;
  import tl_tracker_pkg::*;

  localparam int TO = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       err_clear;
  logic [3:0] inflight_count;
  logic       busy;
  logic       e_dup, e_nr, e_mm, e_to;
  logic [2:0] err_source;
  logic [3:0] ev;

  int n_chk = 0;
  int n_err = 0;

  tl_inflight_tracker_if bus();

  tl_inflight_tracker #(.TIMEOUT_CYCLES(TO), .BEAT_BYTES_LOG2(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus.slave),
    .err_clear      (err_clear),
    .inflight_count (inflight_count),
    .busy           (busy),
    .err_dup_source (e_dup),
    .err_no_request (e_nr),
    .err_mismatch   (e_mm),
    .err_timeout    (e_to),
    .err_source     (err_source)
  );

  always #5 clock = ~clock;

  // {dup, no_req, mismatch, timeout}
  assign ev = {e_dup, e_nr, e_mm, e_to};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] cnt, input logic [3:0] err,
                    input logic [2:0] src);
    chk({tag, ".count"}, inflight_count, cnt);
    chk({tag, ".busy"}, busy, cnt != 0);
    chk({tag, ".err"}, ev, err);
    chk({tag, ".src"}, err_source, src);
  endtask

  task automatic set_a(input logic [2:0] op, input logic [2:0] sz, input logic [2:0] src);
    bus.a_valid = 1'b1; bus.a_ready = 1'b1;
    bus.a_opcode = op; bus.a_size = sz; bus.a_source = src;
    bus.a_address = $urandom;
  endtask

  task automatic set_d(input logic [2:0] op, input logic [2:0] sz, input logic [2:0] src);
    bus.d_valid = 1'b1; bus.d_ready = 1'b1;
    bus.d_opcode = op; bus.d_size = sz; bus.d_source = src;
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    bus.a_valid = 1'b0; bus.a_ready = 1'b0;
    bus.d_valid = 1'b0; bus.d_ready = 1'b0;
    err_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; err_clear = 1'b0;
    bus.a_valid = 1'b0; bus.a_ready = 1'b0; bus.a_opcode = '0; bus.a_size = '0;
    bus.a_source = '0; bus.a_address = '0;
    bus.d_valid = 1'b0; bus.d_ready = 1'b0; bus.d_opcode = '0; bus.d_size = '0;
    bus.d_source = '0;
    step(); step();
    st("reset", 0, 4'b0000, 0);
    reset = 1'b0;

    // Get src 2 answered by a single AccessAckData
    set_a(GET, 3, 2); step(); st("get2", 1, 4'b0000, 0);
    set_d(ACK_DATA, 3, 2); step(); st("ack2", 0, 4'b0000, 0);

    // Get src 5 size 6 -> 8 D beats; pending only drops after the 8th
    set_a(GET, 6, 5); step(); chk("get5.count", inflight_count, 1);
    for (int b = 0; b < 8; b++) begin
      set_d(ACK_DATA, 6, 5); step();
      chk($sformatf("ack5.beat%0d", b), inflight_count, (b < 7) ? 1 : 0);
    end
    st("ack5.end", 0, 4'b0000, 0);

    // a_valid without a_ready is not a fire
    set_a(GET, 3, 3); bus.a_ready = 1'b0; step(); st("stall", 0, 4'b0000, 0);

    // 4-beat PutFull src 6: only the first beat opens the request
    for (int b = 0; b < 4; b++) begin
      set_a(PUT_FULL, 5, 6); step();
      chk($sformatf("put6.beat%0d", b), inflight_count, 1);
    end
    st("put6.end", 1, 4'b0000, 0);
    set_d(ACK, 5, 6); step(); st("ack6", 0, 4'b0000, 0);

    // Duplicate source, then a second error keeps the first source
    set_a(PUT_FULL, 3, 1); step();
    set_a(PUT_FULL, 3, 1); step(); st("dup1", 1, 4'b1000, 1);
    set_d(ACK, 3, 7); step(); st("sticky", 1, 4'b1100, 1);
    err_clear = 1'b1; step(); st("clear1", 1, 4'b0000, 0);
    set_d(ACK, 3, 1); step(); st("ack1", 0, 4'b0000, 0);

    // Response with nothing pending; clear coincident with a new error
    set_d(ACK, 3, 7); step(); st("noreq7", 0, 4'b0100, 7);
    err_clear = 1'b1; set_d(ACK, 3, 6); step(); st("clr_new", 0, 4'b0100, 6);
    err_clear = 1'b1; step(); st("clear2", 0, 4'b0000, 0);

    // Opcode mismatch, then size mismatch
    set_a(GET, 3, 3); step();
    set_d(ACK, 3, 3); step(); st("mm_op", 0, 4'b0010, 3);
    err_clear = 1'b1; step();
    set_a(GET, 2, 3); step();
    set_d(ACK_DATA, 3, 3); step(); st("mm_size", 0, 4'b0010, 3);
    err_clear = 1'b1; step(); st("clear3", 0, 4'b0000, 0);

    // Same-cycle A first beat and D last beat on src 4
    set_a(GET, 3, 4); step();
    set_a(GET, 3, 4); set_d(ACK_DATA, 3, 4); step(); st("reuse4", 1, 4'b0000, 0);
    set_d(ACK_DATA, 3, 4); step(); st("ack4", 0, 4'b0000, 0);

    // D error beats A error for err_source in the same cycle
    set_a(GET, 3, 2); step();
    set_a(GET, 3, 2); set_d(ACK, 3, 7); step(); st("prio", 1, 4'b1100, 7);
    err_clear = 1'b1; step();
    set_d(ACK_DATA, 3, 2); step(); st("prio.end", 0, 4'b0000, 0);

    // Timeout: Get src 0 never answered
    set_a(GET, 3, 0); step();
    for (int i = 1; i < TO; i++) step();
    chk("to.before", e_to, 0);
    step();
`ifdef TL_INFLIGHT_TIMEOUT_EN
    st("to.hit", 1, 4'b0001, 0);
`else
    st("to.off", 1, 4'b0000, 0);
`endif
    err_clear = 1'b1; set_d(ACK_DATA, 3, 0); step(); st("to.end", 0, 4'b0000, 0);

    // Reset mid-burst abandons the partial A message
    set_a(PUT_FULL, 5, 6); step();
    set_a(PUT_FULL, 5, 6); step(); chk("midburst.count", inflight_count, 1);
    reset = 1'b1; step(); reset = 1'b0;
    st("rst2", 0, 4'b0000, 0);
    set_a(PUT_FULL, 3, 2); step(); st("post_rst", 1, 4'b0000, 0);
    set_d(ACK, 3, 2); step(); st("post_rst.ack", 0, 4'b0000, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tl_inflight_tracker.md
TL_INFLIGHT_TRACKER -- requirements
Module: tl_inflight_tracker

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the number of idle cycles with requests outstanding before err_timeout sets.
REQ-002 SHALL have parameter BEAT_BYTES_LOG2, default 3, meaning the link is 8 bytes per beat.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 a_valid, a_ready  in  1  A-channel handshake, observed only; a_fire = a_valid & a_ready.
REQ-006 a_opcode  in  3; a_size  in  3; a_source  in  3; a_address  in  32.
REQ-007 d_valid, d_ready  in  1  D-channel handshake, observed only; d_fire = d_valid & d_ready.
REQ-008 d_opcode  in  3; d_size  in  3; d_source  in  3.
REQ-009 err_clear  in  1  single-cycle pulse that clears sticky errors.
REQ-010 inflight_count  out  4  registered count of pending sources, 0..8.
REQ-011 busy  out  1  inflight_count != 0.
REQ-012 err_dup_source, err_no_request, err_mismatch, err_timeout  out  1 each  sticky error flags.
REQ-013 err_source  out  3  source ID of the first error captured since the last clear or reset.

Function
REQ-014 Beats per message SHALL be 1 when size <= BEAT_BYTES_LOG2; otherwise 1 << (size - BEAT_BYTES_LOG2). Max size 6 = 8 beats; beat counters are 3 bits.
REQ-015 A messages with data are PutFull (0) and PutPartial (1). Get (4) carries no A data. The A beat counter SHALL advance only on data-bearing multi-beat fires and SHALL wrap to 0 on the last beat.
REQ-016 A first-beat fire SHALL:
  - set pending[a_source];
  - record exp_op[a_source] (1 for Get, else 0);
  - record exp_size[a_source] = a_size.
REQ-017 err_dup_source SHALL set on an A first-beat fire when pending[a_source] is set and is not being cleared by a D last beat in the same cycle.
REQ-018 On a D first-beat fire:
  - !pending[d_source] SHALL set err_no_request;
  - otherwise, a mismatch of d_opcode against exp_op, or of d_size against exp_size, SHALL set err_mismatch.
REQ-019 Only AccessAckData (1) SHALL be counted as multi-beat on D. A D last-beat fire SHALL clear pending[d_source].
REQ-020 A first-beat and D last-beat on the same source in the same cycle: pending stays set, holding the new request, with no error.
REQ-021 inflight_count SHALL be the popcount of next-state pending, registered, so it updates one cycle after the fire.
REQ-022 Error capture:
  - error flags SHALL be sticky until err_clear;
  - err_source SHALL load only when no flag is currently set;
  - D-side errors take priority over A-side errors in the same cycle.
REQ-023 err_clear coincident with a new error: the new error SHALL be set and its source captured.
REQ-024 A D fire with no pending source SHALL NOT change the pending state.
REQ-025 The tracker SHALL never drive a_ready or d_ready; it is purely observational.

Reset
REQ-026 With reset high, the following SHALL be 0 on the next edge:
  - pending, exp_op, exp_size;
  - both beat counters and the timeout counter;
  - all outputs.
REQ-027 Reset mid-burst SHALL abandon partial beats. The first fire after reset SHALL be treated as a first beat.

Configuration
REQ-028 With macro TL_INFLIGHT_TIMEOUT_EN defined:
  - a 16-bit counter SHALL increment each cycle that busy is 1 and no d_fire occurs;
  - the counter SHALL reset to 0 on d_fire or when busy is 0;
  - err_timeout SHALL set when the counter reaches TIMEOUT_CYCLES; the counter saturates there.
REQ-029 Without TL_INFLIGHT_TIMEOUT_EN:
  - no counter is built;
  - err_timeout SHALL be tied to 0.

Structure
REQ-030 Package tl_tracker_pkg SHALL hold:
  - opcode constants: PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACK=0, ACK_DATA=1;
  - NUM_SOURCES=8;
  - a beats-from-size function.
REQ-031 A single sub-module, tl_beat_counter, SHALL be instantiated twice, once for A and once for D. Inputs: fire, size, has_data. Outputs: first, last.

Verification
REQ-032 Get src 2 size 3 -> AccessAckData size 3 src 2: inflight_count goes 1 then 0; no errors.
REQ-033 Get src 5 size 6 -> 8 D beats: pending[5] clears only after the 8th beat; inflight_count is 1 throughout the beats.
REQ-034 Two PutFull src 1 without a response -> err_dup_source=1, err_source=1; a following err_clear pulse -> all flags 0.
REQ-035 D AccessAck src 7 with nothing pending -> err_no_request=1, err_source=7, inflight_count=0.
REQ-036 Get src 3 answered with AccessAck (opcode 0) -> err_mismatch=1. Same-cycle A first beat src 4 and D last beat src 4 -> no dup error, pending[4]=1.
REQ-037 With TL_INFLIGHT_TIMEOUT_EN and TIMEOUT_CYCLES=16: Get src 0, no response -> err_timeout=1 at cycle 16 after the fire. Without the macro -> err_timeout remains 0.
